vdp_palette_ctrl: RTL and testbench

Palette-write sequencer and palette-RAM arbiter for the VDP. It assembles CPU palette-port (#2) bytes into RGB entries in either legacy 16-colour (2-byte) or 256-palette (3-byte) format and auto-increments the R#16 palette index. It queues completed entries and shares the single-port palette RAM with the display read path. It sits between the I/O register decoder and the palette RAM, next to the colour-lookup stage.

---
 rtl/vdp_palette_pkg.sv | 55 +++++
 rtl/vdp_palette_if.sv | 34 +++
 rtl/vdp_palette_wq.sv | 54 +++++
 rtl/vdp_palette_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_vdp_palette_ctrl.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/vdp_palette_pkg.sv
// Shared types, constants and helpers for the VDP palette write path.
// Optional power-on palette load is enabled with VDP_PALETTE_INIT_EN.
package vdp_palette_pkg;

    typedef struct packed {
        logic [4:0] r;
        logic [4:0] g;
        logic [4:0] b;
    } rgb15_t;

    typedef struct packed {
        logic [7:0] addr;
        rgb15_t     rgb;
    } pal_wr_t;

    localparam int PAL_WR_W = $bits(pal_wr_t);

    typedef enum logic [1:0] {
        PH_0,
        PH_1,
        PH_2
    } phase_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_INIT,
        ST_RUN
    } init_st_e;

    // MSX2 power-on palette, 3 bits per component, octal digits R,G,B.
    localparam logic [8:0] MSX2_PAL [16] = '{
        9'o000, 9'o000, 9'o161, 9'o373,
        9'o117, 9'o237, 9'o511, 9'o267,
        9'o711, 9'o733, 9'o661, 9'o664,
        9'o141, 9'o625, 9'o555, 9'o777
    };

    function automatic logic [4:0] expand3to5(input logic [2:0] c);
        return {c, c[2:1]};
    endfunction

    function automatic rgb15_t msx2_default(input logic [7:0] idx);
        rgb15_t     v;
        logic [8:0] e;
        v = '0;
        e = MSX2_PAL[idx[3:0]];
        if (idx < 8'd16) begin
            v.r = expand3to5(e[8:6]);
            v.g = expand3to5(e[5:3]);
            v.b = expand3to5(e[2:0]);
        end
        return v;
    endfunction

endpackage

// File: rtl/vdp_palette_if.sv
// CPU palette port, display read request and palette RAM bus.
// master: register decoder/display/testbench side; slave: vdp_palette_ctrl.
interface vdp_palette_if;

    logic        palette256;
    logic        idx_wr;
    logic [7:0]  idx_wdata;
    logic        dat_wr;
    logic [7:0]  dat_wdata;
    logic [7:0]  pal_index;
    logic        disp_rd;
    logic [7:0]  disp_addr;
    logic        ram_we;
    logic [7:0]  ram_addr;
    logic [14:0] ram_wdata;
    logic        busy;
    logic        starve_hit;
    logic        ovf;

    modport master (
        output palette256, idx_wr, idx_wdata, dat_wr, dat_wdata,
        output disp_rd, disp_addr,
        input  pal_index, ram_we, ram_addr, ram_wdata,
        input  busy, starve_hit, ovf
    );

    modport slave (
        input  palette256, idx_wr, idx_wdata, dat_wr, dat_wdata,
        input  disp_rd, disp_addr,
        output pal_index, ram_we, ram_addr, ram_wdata,
        output busy, starve_hit, ovf
    );

endinterface

// File: rtl/vdp_palette_wq.sv
// Palette write queue: DEPTH-entry synchronous FIFO of {addr, rgb}.
// Ports: clk, reset_n, push/wdata, pop/rdata, full, empty.
module vdp_palette_wq #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 23
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/vdp_palette_ctrl.sv
// Palette-write sequencer and palette RAM arbiter (display vs CPU writes).
// Ports: clk, reset_n, bus (vdp_palette_if.slave); VDP_PALETTE_INIT_EN adds power-on load.
module vdp_palette_ctrl
    import vdp_palette_pkg::*;
#(
    parameter int PAL_Q_DEPTH  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    vdp_palette_if.slave bus
);

    localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

    logic          mode_q;
    phase_e        phase_q, phase_d, ph_cur;
    logic [4:0]    r_q, g_q, b_q;
    logic [4:0]    r_d, g_d, b_d;
    logic [4:0]    r_cur, g_cur, b_cur;
    logic [7:0]    idx_q, idx_d, idx_base;
    logic          ovf_q;
    logic [SW-1:0] starve_q, starve_d;
    logic          ram_we_q, we_d;
    logic [7:0]    ram_addr_q, addr_d;
    rgb15_t        ram_wdata_q, data_d;
    logic          hit_q, hit_d;

    logic          legacy, clr, commit, pop;
    pal_wr_t       ent, q_head;
    logic          q_full, q_empty;
    logic          init_active, init_busy;
    logic [7:0]    init_cnt;

    vdp_palette_wq #(
        .DEPTH (PAL_Q_DEPTH),
        .WIDTH (PAL_WR_W)
    ) u_wq (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (commit),
        .wdata   (ent),
        .pop     (pop),
        .rdata   (q_head),
        .full    (q_full),
        .empty   (q_empty)
    );

`ifdef VDP_PALETTE_INIT_EN
    init_st_e   st_q, st_d;
    logic [7:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            st_q  <= ST_IDLE;
            cnt_q <= '0;
        end else begin
            st_q <= st_d;
            if (st_q == ST_INIT) cnt_q <= cnt_q + 8'd1;
        end
    end

    always_comb begin
        st_d = st_q;
        unique case (st_q)
            ST_IDLE: st_d = ST_INIT;
            ST_INIT: if (cnt_q == 8'hFF) st_d = ST_RUN;
            default: st_d = ST_RUN;
        endcase
    end

    assign init_active = (st_q == ST_INIT);
    assign init_busy   = (st_q != ST_RUN);
    assign init_cnt    = cnt_q;
`else
    assign init_active = 1'b0;
    assign init_busy   = 1'b0;
    assign init_cnt    = '0;
`endif

    // Byte assembly. An index load or mode change restarts the
    // sequence before the same-cycle data byte is considered.
    always_comb begin
        legacy   = !bus.palette256;
        clr      = bus.idx_wr || (bus.palette256 != mode_q);
        idx_base = bus.idx_wr ? bus.idx_wdata : idx_q;
        ph_cur   = clr ? PH_0 : phase_q;
        r_cur    = clr ? 5'd0 : r_q;
        g_cur    = clr ? 5'd0 : g_q;
        b_cur    = clr ? 5'd0 : b_q;
        phase_d  = ph_cur;
        r_d      = r_cur;
        g_d      = g_cur;
        b_d      = b_cur;
        idx_d    = idx_base;
        commit   = 1'b0;
        ent      = '0;
        if (bus.dat_wr) begin
            unique case (1'b1)
                legacy && (ph_cur == PH_0): begin
                    r_d     = expand3to5(bus.dat_wdata[6:4]);
                    b_d     = expand3to5(bus.dat_wdata[2:0]);
                    phase_d = PH_1;
                end
                legacy && (ph_cur != PH_0): begin
                    commit  = 1'b1;
                    ent.rgb = '{r: r_cur, g: expand3to5(bus.dat_wdata[2:0]), b: b_cur};
                end
                !legacy && (ph_cur == PH_0): begin
                    r_d     = bus.dat_wdata[7:3];
                    phase_d = PH_1;
                end
                !legacy && (ph_cur == PH_1): begin
                    g_d     = bus.dat_wdata[7:3];
                    phase_d = PH_2;
                end
                default: begin
                    commit  = 1'b1;
                    ent.rgb = '{r: r_cur, g: g_cur, b: bus.dat_wdata[7:3]};
                end
            endcase
        end
        if (commit) begin
            phase_d = PH_0;
            if (legacy) begin
                ent.addr = {4'h0, idx_base[3:0]};
                idx_d    = {4'h0, idx_base[3:0] + 4'd1};
            end else begin
                ent.addr = idx_base;
                idx_d    = idx_base + 8'd1;
            end
        end
    end

    // RAM arbitration; the starve count only grows while a write waits.
    always_comb begin
        pop      = 1'b0;
        we_d     = 1'b0;
        addr_d   = ram_addr_q;
        data_d   = ram_wdata_q;
        hit_d    = 1'b0;
        starve_d = starve_q;
        if (init_busy) begin
            starve_d = '0;
            if (init_active) begin
                we_d   = 1'b1;
                addr_d = init_cnt;
                data_d = msx2_default(init_cnt);
            end
        end else if (bus.disp_rd && (starve_q < LIMIT)) begin
            addr_d = bus.disp_addr;
            if (!q_empty) starve_d = starve_q + 1'b1;
        end else if (!q_empty) begin
            pop      = 1'b1;
            we_d     = 1'b1;
            addr_d   = q_head.addr;
            data_d   = q_head.rgb;
            hit_d    = bus.disp_rd;
            starve_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mode_q      <= bus.palette256;
            phase_q     <= PH_0;
            r_q         <= '0;
            g_q         <= '0;
            b_q         <= '0;
            idx_q       <= '0;
            ovf_q       <= 1'b0;
            starve_q    <= '0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            hit_q       <= 1'b0;
        end else begin
            mode_q      <= bus.palette256;
            phase_q     <= phase_d;
            r_q         <= r_d;
            g_q         <= g_d;
            b_q         <= b_d;
            idx_q       <= idx_d;
            ovf_q       <= ovf_q | (commit & q_full);
            starve_q    <= starve_d;
            ram_we_q    <= we_d;
            ram_addr_q  <= addr_d;
            ram_wdata_q <= data_d;
            hit_q       <= hit_d;
        end
    end

    assign bus.pal_index  = idx_q;
    assign bus.ram_we     = ram_we_q;
    assign bus.ram_addr   = ram_addr_q;
    assign bus.ram_wdata  = ram_wdata_q;
    assign bus.busy       = init_busy | !q_empty;
    assign bus.starve_hit = hit_q;
    assign bus.ovf        = ovf_q;

endmodule

// File: tb/tb_vdp_palette_ctrl.sv
// Self-checking bench for vdp_palette_ctrl: directed cases plus random
// traffic against a queue-based reference model.
`timescale 1ns/1ps
module tb_vdp_palette_ctrl;

    localparam int DEPTH = 2;
    localparam int LIMIT = 4;
`ifdef VDP_PALETTE_INIT_EN
    localparam bit INIT_EN = 1'b1;
`else
    localparam bit INIT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    vdp_palette_if bus();

    vdp_palette_ctrl #(
        .PAL_Q_DEPTH  (DEPTH),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model state
    typedef struct { int addr; int rgb; } ent_t;
    ent_t mq[$];
    int   bytes[$];
    int   m_idx, m_starve, init_stage, init_k;
    bit   m_ovf, m_mode_prev;
    bit   e_we, e_hit;
    int   e_addr, e_data;
    int   wr_count, last_addr, last_data;

    int def_r[16] = '{0,0,1,3,1,2,5,2,7,7,6,6,1,6,5,7};
    int def_g[16] = '{0,0,6,7,1,3,1,6,1,3,6,6,4,2,5,7};
    int def_b[16] = '{0,0,1,3,7,7,1,7,1,3,1,4,1,5,5,7};

    function automatic int x3to5(input int c);
        return c * 4 + c / 2;
    endfunction

    function automatic int def_rgb(input int k);
        if (k >= 16) return 0;
        return x3to5(def_r[k]) * 1024 + x3to5(def_g[k]) * 32 + x3to5(def_b[k]);
    endfunction

    task automatic model_edge();
        int   pre, rgb, addr;
        bit   com;
        ent_t e;
        if (!reset_n) begin
            mq.delete();
            bytes.delete();
            m_idx = 0; m_starve = 0; m_ovf = 0;
            e_we = 0; e_hit = 0; e_addr = 0; e_data = 0;
            m_mode_prev = bus.palette256;
            init_stage = INIT_EN ? 1 : 0;
            return;
        end
        pre  = mq.size();
        e_we = 0;
        e_hit = 0;
        if (init_stage == 1) begin
            init_stage = 2; init_k = 0; m_starve = 0;
        end else if (init_stage == 2) begin
            e_we = 1; e_addr = init_k; e_data = def_rgb(init_k);
            init_k++;
            if (init_k == 256) init_stage = 0;
            m_starve = 0;
        end else if (bus.disp_rd && m_starve < LIMIT) begin
            e_addr = bus.disp_addr;
            if (pre > 0) m_starve++;
        end else if (pre > 0) begin
            e = mq.pop_front();
            e_we = 1; e_addr = e.addr; e_data = e.rgb;
            e_hit = bus.disp_rd; m_starve = 0;
        end
        if (bus.idx_wr || bus.palette256 != m_mode_prev) begin
            bytes.delete();
            if (bus.idx_wr) m_idx = bus.idx_wdata;
        end
        m_mode_prev = bus.palette256;
        com = 0; rgb = 0; addr = 0;
        if (bus.dat_wr) begin
            bytes.push_back(int'(bus.dat_wdata));
            if (bus.palette256 && bytes.size() == 3) begin
                rgb  = (bytes[0] >> 3) * 1024 + (bytes[1] >> 3) * 32 + (bytes[2] >> 3);
                addr = m_idx;
                m_idx = (m_idx + 1) % 256;
                com = 1;
            end else if (!bus.palette256 && bytes.size() == 2) begin
                rgb = x3to5((bytes[0] >> 4) & 7) * 1024 + x3to5(bytes[1] & 7) * 32
                    + x3to5(bytes[0] & 7);
                addr = m_idx % 16;
                m_idx = (m_idx % 16 + 1) % 16;
                com = 1;
            end
        end
        if (com) begin
            bytes.delete();
            if (pre >= DEPTH) m_ovf = 1;
            else mq.push_back('{addr: addr, rgb: rgb});
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("ram_we", bus.ram_we, e_we);
        check("ram_addr", bus.ram_addr, e_addr);
        check("ram_wdata", bus.ram_wdata, e_data);
        check("starve_hit", bus.starve_hit, e_hit);
        check("pal_index", bus.pal_index, m_idx);
        check("busy", bus.busy, (init_stage != 0) || (mq.size() > 0));
        check("ovf", bus.ovf, m_ovf);
        if (bus.ram_we) begin
            wr_count++;
            last_addr = bus.ram_addr;
            last_data = bus.ram_wdata;
        end
    endtask

    task automatic cyc(input bit iw, input int iv, input bit dw, input int dv, input bit dr);
        bus.idx_wr    = iw;
        bus.idx_wdata = 8'(iv);
        bus.dat_wr    = dw;
        bus.dat_wdata = 8'(dv);
        bus.disp_rd   = dr;
        bus.disp_addr = 8'($urandom);
        step();
    endtask

    task automatic idle(input int n, input bit dr);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, dr);
    endtask

    initial begin
        int k, burst;
        bit dr_level;
        reset_n = 1'b0;
        bus.palette256 = 1'b0;
        idle(2, 0);
        check("rst_we", bus.ram_we, 0);
        check("rst_addr", bus.ram_addr, 0);
        check("rst_idx", bus.pal_index, 0);
        check("rst_busy", bus.busy, INIT_EN);
        reset_n = 1'b1;

        if (INIT_EN) begin
            wr_count = 0;
            idle(3, 1);
            cyc(1, 8'h02, 1, 8'h72, 1);
            cyc(0, 0, 1, 8'h05, 1);
            idle(300, 1);
            check("init_writes", wr_count, 257);
            check("init_tail", last_addr, 8'h02);
        end

        // legacy 2-byte entry
        cyc(1, 8'h03, 0, 0, 0);
        cyc(0, 0, 1, 8'h72, 0);
        cyc(0, 0, 1, 8'h05, 0);
        check("leg_idx", bus.pal_index, 8'h04);
        idle(1, 0);
        check("leg_we", bus.ram_we, 1);
        check("leg_addr", bus.ram_addr, 8'h03);
        check("leg_data", bus.ram_wdata, 15'h7EC9);
        idle(1, 0);
        check("leg_busy", bus.busy, 0);

        // 256-mode 3-byte entry
        bus.palette256 = 1'b1;
        cyc(1, 8'h05, 0, 0, 0);
        cyc(0, 0, 1, 8'hF8, 0);
        cyc(0, 0, 1, 8'h00, 0);
        cyc(0, 0, 1, 8'h40, 0);
        check("p256_idx", bus.pal_index, 8'h06);
        idle(1, 0);
        check("p256_addr", bus.ram_addr, 8'h05);
        check("p256_data", bus.ram_wdata, 15'h7C08);

        // index wrap in both modes
        bus.palette256 = 1'b0;
        cyc(1, 8'h0F, 1, 8'h11, 0);
        cyc(0, 0, 1, 8'h03, 0);
        check("wrap_leg", bus.pal_index, 0);
        bus.palette256 = 1'b1;
        cyc(1, 8'hFF, 1, 8'h08, 0);
        cyc(0, 0, 1, 8'h10, 0);
        cyc(0, 0, 1, 8'h18, 0);
        check("wrap_256", bus.pal_index, 0);
        idle(4, 0);

        // display contention: write deferred by the starve limit
        bus.palette256 = 1'b0;
        cyc(1, 8'h07, 0, 0, 1);
        cyc(0, 0, 1, 8'h31, 1);
        cyc(0, 0, 1, 8'h02, 1);
        k = 0;
        do begin
            cyc(0, 0, 0, 0, 1);
            k++;
        end while (!bus.ram_we && k < 20);
        check("starve_lat", k, 5);
        check("starve_pulse", bus.starve_hit, 1);
        idle(3, 0);

        // mid-sequence index reload discards partial bytes
        bus.palette256 = 1'b1;
        cyc(1, 8'h20, 1, 8'h11, 0);
        cyc(0, 0, 1, 8'h22, 0);
        wr_count = 0;
        cyc(1, 8'h10, 0, 0, 0);
        cyc(0, 0, 1, 8'hA8, 0);
        cyc(0, 0, 1, 8'h50, 0);
        cyc(0, 0, 1, 8'h18, 0);
        idle(4, 0);
        check("mid_count", wr_count, 1);
        check("mid_addr", last_addr, 8'h10);
        check("mid_data", last_data, 15'h5543);

        // overflow while the display holds the RAM
        bus.palette256 = 1'b0;
        cyc(1, 8'h00, 1, 8'h11, 1);
        cyc(0, 0, 1, 8'h02, 1);
        cyc(0, 0, 1, 8'h33, 1);
        cyc(0, 0, 1, 8'h04, 1);
        cyc(0, 0, 1, 8'h55, 1);
        cyc(0, 0, 1, 8'h06, 1);
        check("ovf_set", bus.ovf, 1);
        check("ovf_idx", bus.pal_index, 8'h03);
        idle(8, 0);

        // random traffic
        burst = 0;
        dr_level = 0;
        for (int i = 0; i < 4000; i++) begin
            reset_n = ($urandom_range(399) != 0);
            if ($urandom_range(149) == 0) bus.palette256 = ~bus.palette256;
            if (burst == 0) begin
                burst = $urandom_range(12);
                dr_level = bit'($urandom_range(1));
            end else begin
                burst--;
            end
            cyc($urandom_range(15) == 0, int'($urandom), bit'($urandom_range(1)),
                int'($urandom), dr_level);
        end
        reset_n = 1'b1;
        idle(4, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
